// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - time-setting sequencer: mode/inc buttons to field increment strobes
// Optional auto-repeat on a held inc button is built when CLOCK_SET_AUTOREPEAT_EN is defined.
module clock_set_controller #(
    parameter int TIMEOUT_SECS  = 30,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       clk_1hz_en,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       inc_hours_ui,
    output logic       inc_minutes_ui,
    output logic       inc_seconds_ui,
    output logic [1:0] field_sel,
    output logic       set_active,
    output logic       blink
);

    localparam int TW = $clog2(TIMEOUT_SECS + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    if (TIMEOUT_SECS < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("clock_set_controller: TIMEOUT_SECS, HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    state_t          state_q, state_d;
    logic            btn_mode_q, btn_inc_q;
    logic [TW-1:0]   tout_q, tout_d;
    logic            blink_q, blink_d;
    logic            set_active_q, set_active_d;
    logic [2:0]      strobe_q, strobe_d;   // [0]=hours [1]=minutes [2]=seconds

    logic mode_edge, inc_edge, in_set, activity, timeout_hit, press_ok, rep_pulse;

    assign mode_edge   = btn_mode & ~btn_mode_q;
    assign inc_edge    = btn_inc & ~btn_inc_q;
    assign in_set      = (state_q != ST_RUN);
    assign activity    = mode_edge | inc_edge | rep_pulse;
    assign press_ok    = in_set & inc_edge & ~mode_edge;
    assign timeout_hit = in_set & clk_1hz_en & ~activity & (tout_q == TW'(TIMEOUT_SECS - 1));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            btn_mode_q   <= 1'b0;
            btn_inc_q    <= 1'b0;
            tout_q       <= '0;
            blink_q      <= 1'b0;
            set_active_q <= 1'b0;
            strobe_q     <= 3'b000;
        end else begin
            state_q      <= state_d;
            btn_mode_q   <= btn_mode;
            btn_inc_q    <= btn_inc;
            tout_q       <= tout_d;
            blink_q      <= blink_d;
            set_active_q <= set_active_d;
            strobe_q     <= strobe_d;
        end
    end

    // Mode edge outranks everything, including a coincident timeout.
    always_comb begin
        state_d = state_q;
        if (mode_edge) begin
            case (state_q)
                ST_RUN:     state_d = ST_SET_HR;
                ST_SET_HR:  state_d = ST_SET_MIN;
                ST_SET_MIN: state_d = ST_SET_SEC;
                default:    state_d = ST_RUN;
            endcase
        end else if (timeout_hit) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        strobe_d = 3'b000;
        if ((inc_edge | rep_pulse) & in_set & ~mode_edge) begin
            case (state_q)
                ST_SET_HR:  strobe_d[0] = 1'b1;
                ST_SET_MIN: strobe_d[1] = 1'b1;
                ST_SET_SEC: strobe_d[2] = 1'b1;
                default:    strobe_d    = 3'b000;
            endcase
        end

        tout_d = tout_q;
        if (!in_set || activity || (state_d != state_q)) begin
            tout_d = '0;
        end else if (clk_1hz_en) begin
            tout_d = tout_q + TW'(1);
        end

        if (state_d == ST_RUN) begin
            blink_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            blink_d = 1'b1;
        end else begin
            blink_d = blink_q ^ clk_1hz_en;
        end

        set_active_d = (state_d != ST_RUN);
    end

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic          held_q, held_d;
    logic          rep_phase_q, rep_phase_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0] rep_target;
    logic          keep_holding;

    // rcnt_q holds the number of edges since the last press/repeat pulse.
    assign rep_target   = rep_phase_q ? CW'(REPEAT_CYCLES) : CW'(HOLD_CYCLES);
    assign keep_holding = held_q & btn_inc & in_set & ~mode_edge;
    assign rep_pulse    = keep_holding & (rcnt_q == rep_target);

    always_comb begin
        held_d      = 1'b0;
        rep_phase_d = 1'b0;
        rcnt_d      = '0;
        if (press_ok) begin
            held_d = 1'b1;
            rcnt_d = CW'(1);
        end else if (keep_holding && !timeout_hit) begin
            held_d = 1'b1;
            if (rep_pulse) begin
                rep_phase_d = 1'b1;
                rcnt_d      = CW'(1);
            end else begin
                rep_phase_d = rep_phase_q;
                rcnt_d      = rcnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q      <= 1'b0;
            rep_phase_q <= 1'b0;
            rcnt_q      <= '0;
        end else begin
            held_q      <= held_d;
            rep_phase_q <= rep_phase_d;
            rcnt_q      <= rcnt_d;
        end
    end
`else
    logic unused_press_ok;
    assign unused_press_ok = press_ok;
    assign rep_pulse       = 1'b0;
`endif

    assign inc_hours_ui   = strobe_q[0];
    assign inc_minutes_ui = strobe_q[1];
    assign inc_seconds_ui = strobe_q[2];
    assign field_sel      = state_q;
    assign set_active     = set_active_q;
    assign blink          = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - directed and randomized checks of clock_set_controller
module tb_clock_set_controller;

    localparam int TO   = 3;
    localparam int HOLD = 8;
    localparam int REP  = 4;
`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_1hz_en = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       inc_hours_ui, inc_minutes_ui, inc_seconds_ui;
    logic [1:0] field_sel;
    logic       set_active, blink;
    logic [2:0] dut_strobe;

    int checks = 0;
    int errors = 0;

    // Reference model state: field number, idle tick count, hold age in cycles
    int       m_field, m_idle, m_since;
    bit       m_prev_mode, m_prev_inc, m_blink, m_held;
    logic [2:0] m_strobe;

    clock_set_controller #(
        .TIMEOUT_SECS (TO),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .clk_1hz_en    (clk_1hz_en),
        .btn_mode      (btn_mode),
        .btn_inc       (btn_inc),
        .inc_hours_ui  (inc_hours_ui),
        .inc_minutes_ui(inc_minutes_ui),
        .inc_seconds_ui(inc_seconds_ui),
        .field_sel     (field_sel),
        .set_active    (set_active),
        .blink         (blink)
    );

    assign dut_strobe = {inc_seconds_ui, inc_minutes_ui, inc_hours_ui};

    always #5 sys_clk = ~sys_clk;

    task model_reset();
        m_field = 0; m_idle = 0; m_since = 0;
        m_prev_mode = 0; m_prev_inc = 0; m_blink = 0; m_held = 0;
        m_strobe = 3'b000;
    endtask

    task model_step(input bit m, input bit i, input bit t);
        bit me, ie, rep;
        me = m && !m_prev_mode;
        ie = i && !m_prev_inc;
        rep = 0;
        m_strobe = 3'b000;
        if (AR && m_held && i && m_field != 0 && !me) begin
            m_since = m_since + 1;
            rep = (m_since >= HOLD) && (((m_since - HOLD) % REP) == 0);
        end else begin
            m_held = 0;
        end
        if (me) begin
            if (m_field == 0) m_blink = 1;
            else if (m_field == 3) m_blink = 0;
            else m_blink = m_blink ^ t;
            m_field = (m_field + 1) % 4;
            m_idle = 0;
            m_held = 0;
        end else if (m_field != 0) begin
            if (ie || rep) begin
                m_strobe[m_field-1] = 1'b1;
                m_idle = 0;
                if (ie) begin
                    m_held = 1;
                    m_since = 0;
                end
            end
            if (t) begin
                m_blink = !m_blink;
                if (!(ie || rep)) begin
                    m_idle = m_idle + 1;
                    if (m_idle == TO) begin
                        m_field = 0; m_blink = 0; m_idle = 0; m_held = 0;
                    end
                end
            end
        end else begin
            m_idle = 0; m_blink = 0; m_held = 0;
        end
        m_prev_mode = m;
        m_prev_inc = i;
    endtask

    task drive(input bit m, input bit i, input bit t);
        btn_mode = m; btn_inc = i; clk_1hz_en = t;
        @(posedge sys_clk);
        #1;
        model_step(m, i, t);
    endtask

    task press_mode();
        drive(1, 0, 0);
        drive(0, 0, 0);
    endtask

    task test_reset();
        rst_n = 0; btn_mode = 0; btn_inc = 0; clk_1hz_en = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        checks++; if (field_sel !== 2'd0) begin errors++; $display("FAIL reset_field: got %0d expected 0", field_sel); end
        checks++; if (set_active !== 1'b0) begin errors++; $display("FAIL reset_set_active: got %0b expected 0", set_active); end
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL reset_blink: got %0b expected 0", blink); end
        checks++; if (dut_strobe !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %03b expected 000", dut_strobe); end
        @(negedge sys_clk);
        rst_n = 1;
        model_reset();
    endtask

    task test_mode_cycle();
        for (int p = 1; p <= 4; p++) begin
            drive(1, 0, 0);
            checks++; if (field_sel !== 2'(p % 4)) begin errors++; $display("FAIL mode_field: press %0d got %0d expected %0d", p, field_sel, p % 4); end
            checks++; if (set_active !== (p != 4)) begin errors++; $display("FAIL mode_set_active: press %0d got %0b expected %0b", p, set_active, p != 4); end
            checks++; if (blink !== (p != 4)) begin errors++; $display("FAIL mode_blink: press %0d got %0b expected %0b", p, blink, p != 4); end
            checks++; if (dut_strobe !== 3'b000) begin errors++; $display("FAIL mode_strobe: press %0d got %03b expected 000", p, dut_strobe); end
            drive(0, 0, 0);
            checks++; if (dut_strobe !== 3'b000) begin errors++; $display("FAIL mode_strobe_rel: press %0d got %03b expected 000", p, dut_strobe); end
        end
    endtask

    task test_minutes();
        press_mode(); press_mode();
        for (int n = 0; n < 5; n++) begin
            drive(0, 1, 0);
            checks++; if (dut_strobe !== 3'b010) begin errors++; $display("FAIL min_pulse: press %0d got %03b expected 010", n, dut_strobe); end
            drive(0, 1, 0);
            checks++; if (dut_strobe !== 3'b000) begin errors++; $display("FAIL min_one_cycle: press %0d got %03b expected 000", n, dut_strobe); end
            drive(0, 0, 0);
        end
        checks++; if (field_sel !== 2'd2) begin errors++; $display("FAIL min_field: got %0d expected 2", field_sel); end
        press_mode(); press_mode();
        checks++; if (field_sel !== 2'd0) begin errors++; $display("FAIL min_exit: got %0d expected 0", field_sel); end
    endtask

    task test_simultaneous();
        press_mode();
        drive(1, 1, 0);
        checks++; if (field_sel !== 2'd2) begin errors++; $display("FAIL simul_field: got %0d expected 2", field_sel); end
        checks++; if (dut_strobe !== 3'b000) begin errors++; $display("FAIL simul_strobe: got %03b expected 000", dut_strobe); end
        drive(0, 0, 0);
        press_mode(); press_mode();
        for (int n = 0; n < 3; n++) begin
            drive(0, 1, 0);
            checks++; if (dut_strobe !== 3'b000 || field_sel !== 2'd0) begin errors++; $display("FAIL run_inc: got strobes %03b field %0d expected 000 field 0", dut_strobe, field_sel); end
            drive(0, 0, 0);
        end
    endtask

    task test_timeout();
        press_mode(); press_mode(); press_mode();
        checks++; if (field_sel !== 2'd3 || blink !== 1'b1) begin errors++; $display("FAIL to_enter: got field %0d blink %0b expected field 3 blink 1", field_sel, blink); end
        for (int tk = 1; tk <= 3; tk++) begin
            drive(0, 0, 1);
            checks++; if (field_sel !== ((tk < 3) ? 2'd3 : 2'd0)) begin errors++; $display("FAIL to_field: tick %0d got %0d expected %0d", tk, field_sel, (tk < 3) ? 3 : 0); end
            checks++; if (blink !== (tk == 2)) begin errors++; $display("FAIL to_blink: tick %0d got %0b expected %0b", tk, blink, tk == 2); end
            drive(0, 0, 0);
        end
        press_mode(); press_mode(); press_mode();
        drive(0, 0, 1); drive(0, 0, 0);
        drive(0, 0, 1); drive(0, 0, 0);
        drive(0, 1, 0);
        checks++; if (dut_strobe !== 3'b100) begin errors++; $display("FAIL to_inc_strobe: got %03b expected 100", dut_strobe); end
        drive(0, 0, 0);
        for (int tk = 1; tk <= 3; tk++) begin
            drive(0, 0, 1);
            checks++; if (field_sel !== ((tk < 3) ? 2'd3 : 2'd0)) begin errors++; $display("FAIL to_restart: tick %0d got %0d expected %0d", tk, field_sel, (tk < 3) ? 3 : 0); end
            drive(0, 0, 0);
        end
    endtask

    task test_autorepeat();
        bit exp;
        press_mode();
        for (int c = 1; c <= 20; c++) begin
            drive(0, 1, 0);
            exp = (c == 1) || (AR && (c == 9 || c == 13 || c == 17));
            checks++; if (dut_strobe !== {2'b00, exp}) begin errors++; $display("FAIL autorepeat: cycle %0d got %03b expected %03b", c, dut_strobe, {2'b00, exp}); end
        end
        drive(0, 0, 0);
        checks++; if (dut_strobe !== 3'b000) begin errors++; $display("FAIL autorepeat_release: got %03b expected 000", dut_strobe); end
        press_mode(); press_mode(); press_mode();
    endtask

    task test_reset_mid_repeat();
        press_mode();
        for (int c = 1; c <= 9; c++) drive(0, 1, 0);
        #2 rst_n = 0;
        #1;
        checks++; if ({field_sel, set_active, blink, dut_strobe} !== 7'd0) begin errors++; $display("FAIL rst_mid: got %07b expected 0000000", {field_sel, set_active, blink, dut_strobe}); end
        for (int c = 0; c < 3; c++) begin
            @(posedge sys_clk); #1;
            checks++; if ({field_sel, set_active, blink, dut_strobe} !== 7'd0) begin errors++; $display("FAIL rst_hold: got %07b expected 0000000", {field_sel, set_active, blink, dut_strobe}); end
        end
        @(negedge sys_clk);
        rst_n = 1;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 0);
            checks++; if (dut_strobe !== 3'b000 || field_sel !== 2'd0) begin errors++; $display("FAIL rst_release: got strobes %03b field %0d expected 000 field 0", dut_strobe, field_sel); end
        end
        drive(1, 1, 0);
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 0);
            checks++; if (dut_strobe !== 3'b000 || field_sel !== 2'd1) begin errors++; $display("FAIL rst_held_inc: got strobes %03b field %0d expected 000 field 1", dut_strobe, field_sel); end
        end
        drive(0, 0, 0);
        press_mode(); press_mode(); press_mode();
    endtask

    task test_random();
        bit m, i, t;
        i = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                @(negedge sys_clk);
                rst_n = 0;
                #2;
                checks++; if ({field_sel, set_active, blink, dut_strobe} !== 7'd0) begin errors++; $display("FAIL rand_reset: got %07b expected 0000000", {field_sel, set_active, blink, dut_strobe}); end
                @(negedge sys_clk);
                rst_n = 1;
                model_reset();
            end
            m = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) i = !i;
            t = ($urandom_range(0, 3) == 0);
            drive(m, i, t);
            checks++;
            if ({field_sel, set_active, blink, dut_strobe} !== {2'(m_field), m_field != 0, m_blink, m_strobe}) begin
                errors++;
                $display("FAIL random: cycle %0d got fld=%0d act=%0b blk=%0b stb=%03b expected fld=%0d act=%0b blk=%0b stb=%03b",
                         n, field_sel, set_active, blink, dut_strobe, m_field, m_field != 0, m_blink, m_strobe);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mode_cycle();
        test_minutes();
        test_simultaneous();
        test_timeout();
        test_autorepeat();
        test_reset_mid_repeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
